// File: rtl/dual_update.sv
// dual_update: ADMM dual write-back y+=u-z, g+=x-v, saturating; DUAL_UPDATE_RESIDUAL_EN adds the primal residual
module dual_update #(
  parameter int STATE_DIM  = 12,
  parameter int INPUT_DIM  = 4,
  parameter int HORIZON    = 30,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] u_rdaddress,
  output logic [ADDR_WIDTH-1:0] z_rdaddress,
  output logic [ADDR_WIDTH-1:0] y_rdaddress,
  input  logic [DATA_WIDTH-1:0] u_data_out,
  input  logic [DATA_WIDTH-1:0] z_data_out,
  input  logic [DATA_WIDTH-1:0] y_data_out,
  output logic [ADDR_WIDTH-1:0] x_rdaddress,
  output logic [ADDR_WIDTH-1:0] v_rdaddress,
  output logic [ADDR_WIDTH-1:0] g_rdaddress,
  input  logic [DATA_WIDTH-1:0] x_data_out,
  input  logic [DATA_WIDTH-1:0] v_data_out,
  input  logic [DATA_WIDTH-1:0] g_data_out,
  output logic [ADDR_WIDTH-1:0] y_wraddress,
  output logic [DATA_WIDTH-1:0] y_data_in,
  output logic                  y_wren,
  output logic [ADDR_WIDTH-1:0] g_wraddress,
  output logic [DATA_WIDTH-1:0] g_data_in,
  output logic                  g_wren,
  input  logic [31:0]           active_horizon,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] primal_res
);
  localparam int W = DATA_WIDTH;
  localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, UPD_Y, UPD_G, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] h, h_eff, ny, ng, ny_eff, idx;
  logic [1:0] ph;
  logic last;
  logic [ADDR_WIDTH-1:0] y_addr, g_addr;
  logic signed [W-1:0] a_q, b_q, c_q, wd;
  logic signed [W+1:0] sum;

  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_frac_chk
    $error("FRAC_BITS must lie inside the data word");
  end

  // Horizon clamp, element counts and end-of-side detection
  always_comb begin
    h_eff = (active_horizon >= 32'd1 && active_horizon <= 32'(HORIZON)) ? active_horizon : 32'(HORIZON);
    ny_eff = (h_eff - 32'd1) * 32'(INPUT_DIM);
    ny = (h - 32'd1) * 32'(INPUT_DIM);
    ng = h * 32'(STATE_DIM);
    last = (ph == 2'd3) && (idx == ((state == UPD_Y) ? ny : ng) - 32'd1);
  end

  // State register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((ny_eff != 32'd0) ? UPD_Y : UPD_G) : IDLE;
      UPD_Y:   state_nx = last ? UPD_G : UPD_Y;
      UPD_G:   state_nx = last ? DONE : UPD_G;
      DONE:    state_nx = start ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs and read addresses of the active side
  always_comb begin
    busy = (state == UPD_Y) || (state == UPD_G);
    done = state == DONE;
    y_addr = (state == UPD_Y) ? idx[ADDR_WIDTH-1:0] : '0;
    g_addr = (state == UPD_G) ? idx[ADDR_WIDTH-1:0] : '0;
  end

  assign u_rdaddress = y_addr;
  assign z_rdaddress = y_addr;
  assign y_rdaddress = y_addr;
  assign x_rdaddress = g_addr;
  assign v_rdaddress = g_addr;
  assign g_rdaddress = g_addr;

  // a + b - c with two guard bits, clamped to the signed word
  always_comb begin
    sum = $signed({{2{a_q[W-1]}}, a_q}) + $signed({{2{b_q[W-1]}}, b_q}) - $signed({{2{c_q[W-1]}}, c_q});
    wd = (sum > MAXV) ? MAXV[W-1:0] : (sum < MINV) ? MINV[W-1:0] : sum[W-1:0];
  end

  // Four-phase element sequencing: capture in phase 2, write back after phase 3
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      idx <= '0;
      ph <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      y_wren <= 1'b0;
      g_wren <= 1'b0;
      y_wraddress <= '0;
      g_wraddress <= '0;
      y_data_in <= '0;
      g_data_in <= '0;
    end else begin
      y_wren <= 1'b0;
      g_wren <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          h <= h_eff;
          idx <= '0;
          ph <= '0;
        end
      end else if (busy) begin
        ph <= ph + 2'd1;
        if (ph == 2'd2) begin
          a_q <= (state == UPD_Y) ? u_data_out : x_data_out;
          b_q <= (state == UPD_Y) ? y_data_out : g_data_out;
          c_q <= (state == UPD_Y) ? z_data_out : v_data_out;
        end
        if (ph == 2'd3) begin
          idx <= last ? '0 : idx + 32'd1;
          if (state == UPD_Y) begin
            y_wraddress <= idx[ADDR_WIDTH-1:0];
            y_data_in <= wd;
            y_wren <= 1'b1;
          end else begin
            g_wraddress <= idx[ADDR_WIDTH-1:0];
            g_data_in <= wd;
            g_wren <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DUAL_UPDATE_RESIDUAL_EN
  logic signed [W:0] diff;
  logic [W:0] mag;
  logic [W-1:0] res_el;

  // |a - c| of the captured element, saturated to the unsigned word
  always_comb begin
    diff = $signed({a_q[W-1], a_q}) - $signed({c_q[W-1], c_q});
    mag = diff[W] ? -diff : diff;
    res_el = mag[W] ? '1 : mag[W-1:0];
  end

  // Running maximum over the pass, cleared when a pass is accepted
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) primal_res <= '0;
    else if (busy && ph == 2'd3 && res_el > primal_res) primal_res <= res_el;
  end
`else
  assign primal_res = '0;
`endif
endmodule

// File: doc/dual_update.md
# dual_update

ADMM dual-variable update stage, directly downstream of `slack_update` in the FPGA-MPC solver iteration. After the slack projection has written z (input slack) and v (state slack), this block streams u/z/y and x/v/g from their memories. It writes back y ← y + u − z and g ← g + x − v with saturating fixed-point arithmetic (rho = 1). Optionally it also accumulates the primal residual for the convergence check.

## Interface
Parameters:
- STATE_DIM, 12, state dimension nx
- INPUT_DIM, 4, input dimension nu
- HORIZON, 30, maximum horizon N
- DATA_WIDTH, 16, signed two's-complement word width
- FRAC_BITS, 8, fractional bits (carried through only; no multiplies)
- ADDR_WIDTH, 9, memory address width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  level request; sampled in IDLE
- u_rdaddress, z_rdaddress, y_rdaddress  out  ADDR_WIDTH  input-side read addresses
- u_data_out, z_data_out, y_data_out  in  DATA_WIDTH  read data, 2-cycle latency
- x_rdaddress, v_rdaddress, g_rdaddress  out  ADDR_WIDTH  state-side read addresses
- x_data_out, v_data_out, g_data_out  in  DATA_WIDTH  read data, 2-cycle latency
- y_wraddress / y_data_in / y_wren  out  ADDR_WIDTH / DATA_WIDTH / 1  y write port
- g_wraddress / g_data_in / g_wren  out  ADDR_WIDTH / DATA_WIDTH / 1  g write port
- active_horizon  in  32  horizon for this solve
- busy  out  1  high in UPD_Y or UPD_G
- done  out  1  completion level
- primal_res  out  DATA_WIDTH  max |u−z|, |x−v| over the pass; unsigned, saturated

## Operation
- States: IDLE, UPD_Y, UPD_G, DONE.
- IDLE with start=1 latches the effective horizon H:
  - H = active_horizon if 1 ≤ active_horizon ≤ HORIZON, else H = HORIZON.
  - Clears the element counters and primal_res.
- Element counts:
  - Ny = (H−1)·INPUT_DIM.
  - Ng = H·STATE_DIM.
  - The flat index idx counts from 0 and is used directly as the address.
- Transitions:
  - IDLE → UPD_Y if Ny > 0, else IDLE → UPD_G.
  - UPD_Y → UPD_G after element Ny−1.
  - UPD_G → DONE after element Ng−1.
  - DONE → IDLE when start=0.
- Each element uses a 4-phase sequence:
  - P0: drive all three rdaddresses of the active side to idx.
  - P1: wait.
  - P2: capture the three read data values.
  - P3: compute, register wr data/address, set wren.
- Arithmetic:
  - Sign-extend operands to DATA_WIDTH+2 bits; compute a + b − c.
  - Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Residual |a−c| is computed in DATA_WIDTH+1 bits, saturated to DATA_WIDTH, and max-accumulated.
- start while busy or in DONE is ignored.
- DONE: done=1, all wren=0. Holding start high holds DONE. A new pass requires start=0 for at least one cycle.
- Reset values (all outputs): 0. State IDLE. H and counters 0.
- rst mid-operation: next cycle returns to IDLE with wren=0; partial writes are not rolled back.

## Timing
- E0 is the rising edge that samples start in IDLE. P0 of the first element is the cycle after E0.
- wren is high for exactly one cycle: the cycle after that element's P3. This overlaps P0 of the next element, whose read address differs.
- done first high 4·(Ny+Ng)+1 edges after E0, in the same cycle as the final g write.
- busy drops in the same cycle done rises.
- Throughput: 1 element per 4 cycles.
- No write is ever issued for idx ≥ Ny (y) or idx ≥ Ng (g).

## Configuration
- DUAL_UPDATE_RESIDUAL_EN defined: primal_res accumulation logic is compiled in. primal_res is valid while done=1.
- Not defined: the accumulator is removed and primal_res is tied to 0. The port remains present, and the y/g behaviour and timing are identical.

## Test plan
Bench configuration: STATE_DIM=2, INPUT_DIM=1, HORIZON=3, DATA_WIDTH=16, FRAC_BITS=8.
- Basic update: active_horizon=3; u=0x0100, z=0x0080, y=0x0040 at addr 0 → y_wraddress=0, y_data_in=0x00C0, y_wren pulse of one cycle.
- Saturation: y=0x7F00, u=0x0200, z=0xFF00 → 0x7FFF. Then g=0x8100, x=0xFE00, v=0x0200 → g_data_in=0x8000.
- Cycle count: active_horizon=3 (Ny=2, Ng=6) → exactly 2 y writes (addr 0,1), then 6 g writes (addr 0..5). done rises 33 edges after E0.
- Horizon boundaries:
  - active_horizon=1 → no y_wren; 2 g writes; done at 9 edges.
  - active_horizon=0 and active_horizon=7 each → behave as H=3 (done at 33).
- Reset mid-pass: rst=1 for one cycle during UPD_G → next cycle all wren=0, done=0, busy=0. A new start then runs a full 33-cycle pass.
- Residual, macro defined: max |u−z|=0x0080, max |x−v|=0x0300 → primal_res=0x0300 when done. Macro undefined → primal_res=0 throughout.
